branch_seq: RTL
===============

# branch_seq

Hardwired sequencer for the conditional-branch instruction class. It steps the datapath through fetch (T0–T2), condition evaluation (T3) and target computation/PC load (T4–T6) by driving the datapath control strobes directly. It is the parametrised successor to the fixed-timing branch sequence: it adds a generalised condition field, a memory-ready handshake with timeout, illegal-opcode detection and an optional early exit. It sits between the top-level control unit and the `Datapath` strobe inputs.

## Interface
Parameters:
- `DATA_W`, 32: bus width used for condition evaluation.
- `COND_LSB`, 19: LSB of the 3-bit condition field in IR.
- `MEM_TIMEOUT`, 15: maximum wait cycles in T1 before a fault.

Ports:
- `Clock`  in  1: the single clock. All state changes on its rising edge.
- `Clear`  in  1: reset, synchronous, active-high.
- `start`  in  1: begin one instruction; sampled only in IDLE.
- `ir`  in  32: IR register contents; opcode is `ir[31:27]`.
- `bus`  in  DATA_W: BusMux output; carries R[Ra] during T3.
- `mem_rdy`  in  1: memory read data valid.
- `pc_out, mar_in, inc_pc, read, mdr_in, mdr_out, ir_in, gra, r_out, con_in, y_in, c_out, zlo_in, zlo_out, pc_in`  out  1 each: datapath strobes.
- `alu_op`  out  5: ALU control.
- `con_ff`  out  1: registered branch-condition flag.
- `busy`  out  1: high in every state except IDLE.
- `done`  out  1: one-cycle pulse on completion.
- `illegal`  out  1: sticky; non-branch opcode decoded.
- `fault`  out  1: sticky; memory timeout.

## Operation
- States: IDLE, T0, T1, T2, T3, T4, T5, T6, DONE.
- IDLE → T0 when `start` = 1. All other states advance unconditionally, except as noted below.
- T0: `pc_out`, `mar_in`, `inc_pc`.
- T1: `read` and `mdr_in` held high. Advance to T2 on the edge where `mem_rdy` = 1. The wait counter increments each cycle `mem_rdy` = 0. When the count reaches `MEM_TIMEOUT`, set `fault` and go to IDLE.
- T2: `mdr_out`, `ir_in`. The opcode is checked at the end of T2 (IR is valid on `ir` from the following cycle, so the check uses `bus[31:27]`). If it is not `BR_OPCODE` (5'b10010), set `illegal` and go to IDLE.
- T3: `gra`, `r_out`, `con_in`. At the end of T3, `con_ff` is loaded with `cond(ir[COND_LSB+2:COND_LSB], bus)`.
- Condition codes:
  - 000 zr: bus == 0
  - 001 nz: bus != 0
  - 010 pl: MSB == 0
  - 011 mi: MSB == 1
  - 100 always
  - 101 never
  - 110 gt: MSB == 0 and bus != 0
  - 111 le: MSB == 1 or bus == 0
- T4: `pc_out`, `y_in`.
- T5: `c_out`, `zlo_in`, `alu_op` = `ALU_ADD` (5'b00000).
- T6: `zlo_out`; `pc_in` = `con_ff`.
- DONE: `done` = 1, then IDLE.
- `alu_op` is `ALU_ADD` in all states.
- `illegal` and `fault` are cleared only by `Clear` or by a new `start` accepted in IDLE.

## Timing
- Strobes are Moore outputs decoded from the registered state. `con_ff`, `illegal`, `fault` and the wait counter are registered.
- `start` sampled at edge k → T0 during cycle k+1.
- With `mem_rdy` already high: T6 in cycle k+7, `done` in cycle k+8. Each low-`mem_rdy` cycle in T1 adds one cycle.
- A `mem_rdy` pulse of one cycle while in T1 is sufficient. `mem_rdy` outside T1 is ignored.
- `start` while `busy` is ignored; there is no queuing.
- Reset: every output is 0, the state is IDLE and the wait counter is 0 on the edge after `Clear` is sampled high, including mid-instruction. `Clear` has priority over `start`.
- Timeout: with `MEM_TIMEOUT` = 15 and `mem_rdy` stuck low, `fault` rises 15 cycles after entering T1. `busy` falls in the same cycle.

## Configuration
- `BR_EARLY_EXIT_EN` defined: from T3, if the freshly computed condition is false, go directly to DONE, skipping T4–T6. `done` then arrives at k+5. Taken branches are unchanged.
- `BR_EARLY_EXIT_EN` undefined: the full T4–T6 sequence always runs, and `pc_in` stays 0 when the branch is not taken.

## Structure
- Package `br_pkg`: the state enum, the `COND_*` codes, `BR_OPCODE`, and `ALU_ADD`.
- Sub-module `br_cond_eval`: combinational, parametrised by `DATA_W`. Inputs are the 3-bit code and the bus value; output is a 1-bit condition. `branch_seq` instantiates it once.

## Test plan
- IR 0x91000023 (brzr R2,35), R2 = 0, `mem_rdy` tied 1 → `con_ff` = 1, `pc_in` high in cycle k+7, `done` in cycle k+8.
- IR 0x91080023 (brnz), R2 = 0 → `con_ff` = 0 and `pc_in` never high. Without `BR_EARLY_EXIT_EN`, `done` at k+8; with it, `done` at k+5.
- IR 0x91180023 (brmi), R2 = 0x80000000 → taken. IR 0x91100023 (brpl) with the same R2 → not taken.
- `mem_rdy` low for 3 cycles in T1 → `done` at k+11. `mem_rdy` held low → `fault` = 1 at T1 entry + 15, then IDLE.
- IR 0x09000000 fetched → `illegal` = 1, return to IDLE after T2, no T3 strobes.
- `Clear` asserted in T4 → all strobes and `con_ff` are 0 next cycle. `start` then runs a clean instruction.

Source files
------------

// File: rtl/br_pkg.sv
// Shared types and constants for the conditional-branch sequencer.
package br_pkg;

  typedef enum logic [3:0] {
    S_IDLE = 4'd0,
    S_T0   = 4'd1,
    S_T1   = 4'd2,
    S_T2   = 4'd3,
    S_T3   = 4'd4,
    S_T4   = 4'd5,
    S_T5   = 4'd6,
    S_T6   = 4'd7,
    S_DONE = 4'd8
  } br_state_t;

  localparam logic [2:0] COND_ZR = 3'b000;
  localparam logic [2:0] COND_NZ = 3'b001;
  localparam logic [2:0] COND_PL = 3'b010;
  localparam logic [2:0] COND_MI = 3'b011;
  localparam logic [2:0] COND_AL = 3'b100;
  localparam logic [2:0] COND_NV = 3'b101;
  localparam logic [2:0] COND_GT = 3'b110;
  localparam logic [2:0] COND_LE = 3'b111;

  localparam logic [4:0] BR_OPCODE = 5'b10010;
  localparam logic [4:0] ALU_ADD   = 5'b00000;

  // Moore strobes that depend only on the state (pc_in also needs con_ff).
  typedef struct packed {
    logic pc_out;
    logic mar_in;
    logic inc_pc;
    logic read;
    logic mdr_in;
    logic mdr_out;
    logic ir_in;
    logic gra;
    logic r_out;
    logic con_in;
    logic y_in;
    logic c_out;
    logic zlo_in;
    logic zlo_out;
    logic busy;
    logic done;
  } br_strb_t;

  function automatic br_strb_t strb_of(input br_state_t s);
    br_strb_t o;
    o = '0;
    o.busy = (s != S_IDLE);
    case (s)
      S_T0:   begin o.pc_out = 1'b1; o.mar_in = 1'b1; o.inc_pc = 1'b1; end
      S_T1:   begin o.read = 1'b1; o.mdr_in = 1'b1; end
      S_T2:   begin o.mdr_out = 1'b1; o.ir_in = 1'b1; end
      S_T3:   begin o.gra = 1'b1; o.r_out = 1'b1; o.con_in = 1'b1; end
      S_T4:   begin o.pc_out = 1'b1; o.y_in = 1'b1; end
      S_T5:   begin o.c_out = 1'b1; o.zlo_in = 1'b1; end
      S_T6:   o.zlo_out = 1'b1;
      S_DONE: o.done = 1'b1;
      default: ;
    endcase
    return o;
  endfunction

endpackage

// File: rtl/branch_seq_if.sv
// Control-unit / datapath signal bundle for the branch sequencer.
interface branch_seq_if #(
  parameter int unsigned DATA_W = 32
);
  logic              start;
  logic [31:0]       ir;
  logic [DATA_W-1:0] bus;
  logic              mem_rdy;

  logic pc_out, mar_in, inc_pc, read, mdr_in, mdr_out, ir_in;
  logic gra, r_out, con_in, y_in, c_out, zlo_in, zlo_out, pc_in;
  logic [4:0] alu_op;
  logic con_ff, busy, done, illegal, fault;

  modport master (
    output start, ir, bus, mem_rdy,
    input  pc_out, mar_in, inc_pc, read, mdr_in, mdr_out, ir_in,
           gra, r_out, con_in, y_in, c_out, zlo_in, zlo_out, pc_in,
           alu_op, con_ff, busy, done, illegal, fault
  );

  modport slave (
    input  start, ir, bus, mem_rdy,
    output pc_out, mar_in, inc_pc, read, mdr_in, mdr_out, ir_in,
           gra, r_out, con_in, y_in, c_out, zlo_in, zlo_out, pc_in,
           alu_op, con_ff, busy, done, illegal, fault
  );
endinterface

// File: rtl/br_cond_eval.sv
// Combinational branch-condition evaluator over the bus value.
module br_cond_eval
  import br_pkg::*;
#(
  parameter int unsigned DATA_W = 32
) (
  input  logic [2:0]        i_code,
  input  logic [DATA_W-1:0] i_bus,
  output logic              o_cond
);

  logic w_zero;
  logic w_msb;

  assign w_zero = (i_bus == '0);
  assign w_msb  = i_bus[DATA_W-1];

  always_comb begin
    o_cond = 1'b0;
    case (i_code)
      COND_ZR: o_cond = w_zero;
      COND_NZ: o_cond = !w_zero;
      COND_PL: o_cond = !w_msb;
      COND_MI: o_cond = w_msb;
      COND_AL: o_cond = 1'b1;
      COND_NV: o_cond = 1'b0;
      COND_GT: o_cond = !w_msb && !w_zero;
      COND_LE: o_cond = w_msb || w_zero;
      default: o_cond = 1'b0;
    endcase
  end

endmodule

// File: rtl/branch_seq.sv
// Hardwired sequencer for conditional-branch instructions (fetch, condition, PC load).
// Optional feature macro: BR_EARLY_EXIT_EN (skip T4-T6 when the branch is not taken).
module branch_seq
  import br_pkg::*;
#(
  parameter int unsigned DATA_W      = 32,
  parameter int unsigned COND_LSB    = 19,
  parameter int unsigned MEM_TIMEOUT = 15
) (
  input  logic         Clock,
  input  logic         Clear,
  branch_seq_if.slave  bif
);

  localparam int unsigned CNT_W = $clog2(MEM_TIMEOUT + 1);

  br_state_t        r_state;
  br_strb_t         r_strb;
  logic             r_pc_in;
  logic             r_con_ff;
  logic             r_illegal;
  logic             r_fault;
  logic [CNT_W-1:0] r_wait_cnt;

  logic       w_cond;
  logic [4:0] w_opcode;
  logic       w_unused_ir;

  assign w_opcode    = bif.bus[31:27];
  assign w_unused_ir = ^bif.ir;

  br_cond_eval #(
    .DATA_W (DATA_W)
  ) u_cond (
    .i_code (bif.ir[COND_LSB+2:COND_LSB]),
    .i_bus  (bif.bus),
    .o_cond (w_cond)
  );

  // Strobes are registered alongside the state so they decode the state being entered.
  always_ff @(posedge Clock) begin
    if (Clear) begin
      r_state    <= S_IDLE;
      r_strb     <= '0;
      r_pc_in    <= 1'b0;
      r_con_ff   <= 1'b0;
      r_illegal  <= 1'b0;
      r_fault    <= 1'b0;
      r_wait_cnt <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (bif.start) begin
            r_state   <= S_T0;
            r_strb    <= strb_of(S_T0);
            r_illegal <= 1'b0;
            r_fault   <= 1'b0;
          end
        end
        S_T0: begin
          r_state    <= S_T1;
          r_strb     <= strb_of(S_T1);
          r_wait_cnt <= '0;
        end
        S_T1: begin
          if (bif.mem_rdy) begin
            r_state    <= S_T2;
            r_strb     <= strb_of(S_T2);
            r_wait_cnt <= '0;
          end else if (r_wait_cnt == CNT_W'(MEM_TIMEOUT - 1)) begin
            r_state    <= S_IDLE;
            r_strb     <= strb_of(S_IDLE);
            r_fault    <= 1'b1;
            r_wait_cnt <= '0;
          end else begin
            r_wait_cnt <= r_wait_cnt + CNT_W'(1);
          end
        end
        S_T2: begin
          // IR is not yet updated here, so the opcode is taken from the bus.
          if (w_opcode != BR_OPCODE) begin
            r_state   <= S_IDLE;
            r_strb    <= strb_of(S_IDLE);
            r_illegal <= 1'b1;
          end else begin
            r_state <= S_T3;
            r_strb  <= strb_of(S_T3);
          end
        end
        S_T3: begin
          r_con_ff <= w_cond;
`ifdef BR_EARLY_EXIT_EN
          if (!w_cond) begin
            r_state <= S_DONE;
            r_strb  <= strb_of(S_DONE);
          end else begin
            r_state <= S_T4;
            r_strb  <= strb_of(S_T4);
          end
`else
          r_state <= S_T4;
          r_strb  <= strb_of(S_T4);
`endif
        end
        S_T4: begin
          r_state <= S_T5;
          r_strb  <= strb_of(S_T5);
        end
        S_T5: begin
          r_state <= S_T6;
          r_strb  <= strb_of(S_T6);
          r_pc_in <= r_con_ff;
        end
        S_T6: begin
          r_state <= S_DONE;
          r_strb  <= strb_of(S_DONE);
          r_pc_in <= 1'b0;
        end
        S_DONE: begin
          r_state <= S_IDLE;
          r_strb  <= strb_of(S_IDLE);
        end
        default: begin
          r_state <= S_IDLE;
          r_strb  <= '0;
          r_pc_in <= 1'b0;
        end
      endcase
    end
  end

  assign bif.pc_out  = r_strb.pc_out;
  assign bif.mar_in  = r_strb.mar_in;
  assign bif.inc_pc  = r_strb.inc_pc;
  assign bif.read    = r_strb.read;
  assign bif.mdr_in  = r_strb.mdr_in;
  assign bif.mdr_out = r_strb.mdr_out;
  assign bif.ir_in   = r_strb.ir_in;
  assign bif.gra     = r_strb.gra;
  assign bif.r_out   = r_strb.r_out;
  assign bif.con_in  = r_strb.con_in;
  assign bif.y_in    = r_strb.y_in;
  assign bif.c_out   = r_strb.c_out;
  assign bif.zlo_in  = r_strb.zlo_in;
  assign bif.zlo_out = r_strb.zlo_out;
  assign bif.pc_in   = r_pc_in;
  assign bif.alu_op  = ALU_ADD;
  assign bif.con_ff  = r_con_ff;
  assign bif.busy    = r_strb.busy;
  assign bif.done    = r_strb.done;
  assign bif.illegal = r_illegal;
  assign bif.fault   = r_fault;

endmodule
